// File: rtl/apb_slave_regbank.sv
// apb_slave_regbank: APB completer holding a word-addressed register bank.
// Access phases are stretched by a wait counter. Out-of-range and misaligned
// accesses complete with pslverr=1.
//
// Ports:
//   clk      - clock, all logic on rising edge
//   rst      - synchronous active-high reset
//   psel     - slave select
//   penable  - access-phase indicator
//   pwrite   - 1 = write, 0 = read
//   paddr    - byte address (ADDR_WIDTH)
//   pwdata   - write data (DATA_WIDTH)
//   prdata   - read data; nonzero only in the completing cycle of a good read
//   pready   - transfer completion (combinational from state/counter)
//   pslverr  - error response, only asserted together with pready
//
// Optional feature macro: APB_SLAVE_RAND_WAIT_EN
//   When defined, an 8-bit LFSR picks 0..WAIT_CYCLES wait states per transfer.
//   When undefined, every transfer uses exactly WAIT_CYCLES wait states.
module apb_slave_regbank #(
    parameter int unsigned             ADDR_WIDTH  = 32,
    parameter int unsigned             DATA_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0]   BASE_ADDR   = ADDR_WIDTH'(32'h0002_F000),
    parameter int unsigned             DEPTH       = 64,
    parameter int unsigned             WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr
);

    localparam int unsigned BYTES      = DATA_WIDTH / 8;
    localparam int unsigned BYTE_SHIFT = $clog2(BYTES);
    localparam int unsigned IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W      = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    // One extra bit so the bank size itself is representable.
    localparam logic [ADDR_WIDTH:0] BANK_BYTES = (ADDR_WIDTH + 1)'(DEPTH * BYTES);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic                    err_q;
    logic                    write_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [IDX_W-1:0]        idx_q;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    setup;
    logic [ADDR_WIDTH-1:0]   offset;
    logic                    addr_err;
    logic [CNT_W-1:0]        wait_load;

    // Range check on the offset so a base near the top of the space cannot wrap.
    assign offset   = paddr - BASE_ADDR;
    assign addr_err = (paddr < BASE_ADDR)
                   || ({1'b0, offset} >= BANK_BYTES)
                   || (paddr[1:0] != 2'b00);

    assign setup = (state == IDLE) && psel && !penable;

`ifdef APB_SLAVE_RAND_WAIT_EN
    logic [7:0] lfsr;

    // Fibonacci LFSR, taps 8,6,5,4; steps once per accepted setup.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= 8'hA5;
        end else if (setup) begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    assign wait_load = CNT_W'(32'(lfsr) % (WAIT_CYCLES + 1));
`else
    assign wait_load = CNT_W'(WAIT_CYCLES);
`endif

    // Completion requires the master to still be in a valid access phase.
    assign pready  = (state == ACCESS) && psel && penable && (cnt == '0);
    assign pslverr = pready && err_q;
    assign prdata  = (pready && !write_q && !err_q) ? mem[idx_q] : '0;

    // Transfer FSM, captured request and register bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            err_q   <= 1'b0;
            write_q <= 1'b0;
            wdata_q <= '0;
            idx_q   <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (setup) begin
                        state   <= ACCESS;
                        cnt     <= wait_load;
                        err_q   <= addr_err;
                        write_q <= pwrite;
                        wdata_q <= pwdata;
                        idx_q   <= IDX_W'(offset >> BYTE_SHIFT);
                    end
                end
                ACCESS: begin
                    if (!psel || !penable) begin
                        // Master abandoned the transfer: drop it silently.
                        state <= IDLE;
                    end else if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        state <= IDLE;
                        if (write_q && !err_q) begin
                            mem[idx_q] <= wdata_q;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_slave_regbank.sv
// tb_apb_slave_regbank: randomized self-checking bench for apb_slave_regbank.
// A behavioural model (word array plus address rules) predicts wait count,
// error response and read data for every transfer.
module tb_apb_slave_regbank;

    localparam int unsigned WAITS  = 2;
    localparam int unsigned NWORDS = 64;
    localparam logic [31:0] BASE   = 32'h0002_F000;

    logic        clk;
    logic        rst;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] model_mem [NWORDS];
`ifdef APB_SLAVE_RAND_WAIT_EN
    logic [7:0]  model_lfsr;
`endif

    apb_slave_regbank #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .BASE_ADDR  (BASE),
        .DEPTH      (NWORDS),
        .WAIT_CYCLES(WAITS)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .psel   (psel),
        .penable(penable),
        .pwrite (pwrite),
        .paddr  (paddr),
        .pwdata (pwdata),
        .prdata (prdata),
        .pready (pready),
        .pslverr(pslverr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic bit model_err(input logic [31:0] a);
        logic [31:0] off;
        if (a < BASE) return 1'b1;
        off = a - BASE;
        return (off >= NWORDS * 4) || (a[1:0] != 2'b00);
    endfunction

    function automatic int model_idx(input logic [31:0] a);
        return int'((a - BASE) / 4);
    endfunction

    function automatic int model_next_wait();
        int w;
`ifdef APB_SLAVE_RAND_WAIT_EN
        w = int'(model_lfsr) % (WAITS + 1);
        model_lfsr = {model_lfsr[6:0], model_lfsr[7] ^ model_lfsr[5] ^ model_lfsr[4] ^ model_lfsr[3]};
`else
        w = WAITS;
`endif
        return w;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < int'(NWORDS); i++) model_mem[i] = '0;
`ifdef APB_SLAVE_RAND_WAIT_EN
        model_lfsr = 8'hA5;
`endif
    endtask

    // ---------------- bus driver (no checking) ----------------
    // Called just after a rising edge; returns just after a rising edge.
    task automatic apb_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                            input bit keep_sel, output logic [31:0] rd, output logic err,
                            output int waits, output bit idle_bad);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
        @(posedge clk); #1;
        penable = 1'b1;
        waits = 0;
        idle_bad = 1'b0;
        @(negedge clk);
        while (pready !== 1'b1 && waits < 40) begin
            if (pslverr !== 1'b0 || prdata !== 32'h0) idle_bad = 1'b1;
            waits++;
            @(negedge clk);
        end
        rd  = prdata;
        err = pslverr;
        @(posedge clk); #1;
        if (!keep_sel) begin
            psel = 1'b0; penable = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        @(negedge clk);
        n_cmp++; if (pready !== 1'b0) begin n_bad++; $display("FAIL reset_pready: got %b expected 0", pready); end
        n_cmp++; if (pslverr !== 1'b0) begin n_bad++; $display("FAIL reset_pslverr: got %b expected 0", pslverr); end
        n_cmp++; if (prdata !== 32'h0) begin n_bad++; $display("FAIL reset_prdata: got %h expected 0", prdata); end
        // penable with no preceding setup must be ignored
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = BASE;
        repeat (3) begin
            @(negedge clk);
            n_cmp++; if (pready !== 1'b0) begin n_bad++; $display("FAIL idle_penable: got pready %b expected 0", pready); end
        end
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        logic [31:0] rd; logic err; int w; int ew; bit bad;
        ew = model_next_wait();
        apb_xfer(1'b1, BASE + 32'h4, 32'hDEAD_BEEF, 1'b0, rd, err, w, bad);
        model_mem[1] = 32'hDEAD_BEEF;
        n_cmp++; if (w != ew) begin n_bad++; $display("FAIL wr_waits: got %0d expected %0d", w, ew); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL wr_err: got %b expected 0", err); end
        n_cmp++; if (bad) begin n_bad++; $display("FAIL wr_wait_outputs: got nonzero pslverr/prdata expected 0"); end
        ew = model_next_wait();
        apb_xfer(1'b0, BASE + 32'h4, 32'h0, 1'b0, rd, err, w, bad);
        n_cmp++; if (w != ew) begin n_bad++; $display("FAIL rd_waits: got %0d expected %0d", w, ew); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rd_err: got %b expected 0", err); end
        n_cmp++; if (rd !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL rd_data: got %h expected deadbeef", rd); end
    endtask

    task automatic test_out_of_range();
        logic [31:0] rd; logic err; int w; int ew; bit bad;
        ew = model_next_wait();
        apb_xfer(1'b0, BASE + 32'h100, 32'h0, 1'b0, rd, err, w, bad);
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL oor_high_err: got %b expected 1", err); end
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL oor_high_data: got %h expected 0", rd); end
        n_cmp++; if (w != ew) begin n_bad++; $display("FAIL oor_high_waits: got %0d expected %0d", w, ew); end
        ew = model_next_wait();
        apb_xfer(1'b0, BASE + 32'hFC, 32'h0, 1'b0, rd, err, w, bad);
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL last_word_err: got %b expected 0", err); end
        n_cmp++; if (rd !== model_mem[63]) begin n_bad++; $display("FAIL last_word_data: got %h expected %h", rd, model_mem[63]); end
        ew = model_next_wait();
        apb_xfer(1'b0, BASE - 32'h4, 32'h0, 1'b0, rd, err, w, bad);
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL oor_low_err: got %b expected 1", err); end
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL oor_low_data: got %h expected 0", rd); end
    endtask

    task automatic test_misaligned();
        logic [31:0] rd; logic err; int w; int ew; bit bad;
        ew = model_next_wait();
        apb_xfer(1'b1, BASE + 32'h6, 32'h1234_5678, 1'b0, rd, err, w, bad);
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL misalign_err: got %b expected 1", err); end
        n_cmp++; if (w != ew) begin n_bad++; $display("FAIL misalign_waits: got %0d expected %0d", w, ew); end
        ew = model_next_wait();
        apb_xfer(1'b0, BASE + 32'h4, 32'h0, 1'b0, rd, err, w, bad);
        n_cmp++; if (rd !== model_mem[1]) begin n_bad++; $display("FAIL misalign_keep: got %h expected %h", rd, model_mem[1]); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic err; int w; int ew; bit bad;
        ew = model_next_wait();
        apb_xfer(1'b1, BASE + 32'h10, 32'hA5A5_0001, 1'b1, rd, err, w, bad);
        model_mem[4] = 32'hA5A5_0001;
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL b2b_wr_err: got %b expected 0", err); end
        n_cmp++; if (w != ew) begin n_bad++; $display("FAIL b2b_wr_waits: got %0d expected %0d", w, ew); end
        ew = model_next_wait();
        apb_xfer(1'b0, BASE + 32'h10, 32'h0, 1'b0, rd, err, w, bad);
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL b2b_rd_err: got %b expected 0", err); end
        n_cmp++; if (w != ew) begin n_bad++; $display("FAIL b2b_rd_waits: got %0d expected %0d", w, ew); end
        n_cmp++; if (rd !== 32'hA5A5_0001) begin n_bad++; $display("FAIL b2b_rd_data: got %h expected a5a50001", rd); end
    endtask

    task automatic test_abort();
        logic [31:0] rd; logic err; int w; int ew; bit bad;
        ew = model_next_wait();
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = BASE + 32'h20; pwdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        if (ew > 0) begin
            penable = 1'b1;
            @(negedge clk);
            n_cmp++; if (pready !== 1'b0) begin n_bad++; $display("FAIL abort_wait1: got pready %b expected 0", pready); end
            @(posedge clk); #1;
        end
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        n_cmp++; if (pready !== 1'b0) begin n_bad++; $display("FAIL abort_pready: got %b expected 0", pready); end
        @(posedge clk); #1;
        ew = model_next_wait();
        apb_xfer(1'b0, BASE + 32'h20, 32'h0, 1'b0, rd, err, w, bad);
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL abort_no_write: got %h expected 0", rd); end
        n_cmp++; if (w != ew) begin n_bad++; $display("FAIL abort_next_waits: got %0d expected %0d", w, ew); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic err; int w; int ew; bit bad;
        ew = model_next_wait();
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = BASE + 32'h4; pwdata = 32'h0BAD_F00D;
        @(posedge clk); #1;
        penable = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        n_cmp++; if (pready !== 1'b0) begin n_bad++; $display("FAIL rstmid_pready: got %b expected 0", pready); end
        n_cmp++; if (prdata !== 32'h0) begin n_bad++; $display("FAIL rstmid_prdata: got %h expected 0", prdata); end
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        ew = model_next_wait();
        apb_xfer(1'b0, BASE + 32'h4, 32'h0, 1'b0, rd, err, w, bad);
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL rstmid_word: got %h expected 0", rd); end
        n_cmp++; if (w != ew) begin n_bad++; $display("FAIL rstmid_waits: got %0d expected %0d", w, ew); end
        ew = model_next_wait();
        apb_xfer(1'b0, BASE + 32'h10, 32'h0, 1'b0, rd, err, w, bad);
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL rstmid_clear: got %h expected 0", rd); end
    endtask

    task automatic test_random();
        logic [31:0] rd; logic err; int w; int ew; bit bad;
        logic [31:0] addr; logic [31:0] data; bit wr; bit keep; bit eerr; logic [31:0] erd;
        int kind;
        for (int i = 0; i < 200; i++) begin
            kind = int'($urandom_range(0, 9));
            case (kind)
                6:       addr = BASE + 4 * $urandom_range(0, 63) + $urandom_range(1, 3);
                7:       addr = BASE + 32'h100 + 4 * $urandom_range(0, 1000);
                8:       addr = $urandom_range(0, 32'h0002_EFFF) & ~32'h3;
                9:       addr = 32'hFFFF_FFFC - 4 * $urandom_range(0, 3);
                default: addr = BASE + 4 * $urandom_range(0, 15);
            endcase
            wr   = 1'($urandom_range(0, 1));
            keep = 1'($urandom_range(0, 1));
            data = $urandom();
            eerr = model_err(addr);
            ew   = model_next_wait();
            erd  = (!wr && !eerr) ? model_mem[model_idx(addr)] : 32'h0;
            apb_xfer(wr, addr, data, keep, rd, err, w, bad);
            n_cmp++; if (err !== eerr) begin n_bad++; $display("FAIL rand_err[%0d]: addr %h got %b expected %b", i, addr, err, eerr); end
            n_cmp++; if (rd !== erd) begin n_bad++; $display("FAIL rand_data[%0d]: addr %h got %h expected %h", i, addr, rd, erd); end
            n_cmp++; if (w != ew) begin n_bad++; $display("FAIL rand_waits[%0d]: got %0d expected %0d", i, w, ew); end
            n_cmp++; if (bad) begin n_bad++; $display("FAIL rand_wait_outputs[%0d]: got nonzero pslverr/prdata expected 0", i); end
            if (wr && !eerr) model_mem[model_idx(addr)] = data;
        end
        psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_out_of_range();
        test_misaligned();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
